// File: rtl/draw_priority_mux_pkg.sv
// Shared constants and helpers for the draw-request multiplexer.
// Mode encodings select between lowest-index priority and strict one-hot drawing.
package draw_mux_pkg;

    localparam logic [7:0] DEFAULT_TRANSP_RGB = 8'hFF;

    localparam int MODE_PRIORITY = 0;
    localparam int MODE_ONEHOT   = 1;

    // Index width that stays at least one bit even for degenerate channel counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/draw_priority_mux_priority_enc.sv
// Combinational lowest-index priority encoder.
// Also flags whether any request, or two or more requests, are present.
module priority_enc
    import draw_mux_pkg::*;
#(
    parameter int NUM_CH = 16
) (
    input  logic [NUM_CH-1:0]                i_eff,
    output logic [idx_width(NUM_CH)-1:0]     o_idx,
    output logic                             o_any,
    output logic                             o_multi
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic w_seen;

    always_comb begin
        o_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_eff[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_seen  = 1'b0;
        o_multi = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i_eff[i]) begin
                if (w_seen) begin
                    o_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
        o_any = w_seen;
    end

endmodule

// File: rtl/draw_priority_mux.sv
// N-channel draw-request multiplexer with transparency keying, selectable
// arbitration and per-frame collision accumulation; all outputs registered.
module draw_priority_mux
    import draw_mux_pkg::*;
#(
    parameter int                 NUM_CH    = 16,
    parameter int                 RGB_W     = 8,
    parameter bit                 TRANSP_EN = 1'b1,
    parameter logic [RGB_W-1:0]   TRANSP_RGB = RGB_W'(DEFAULT_TRANSP_RGB),
    parameter int                 MODE      = MODE_PRIORITY,
    parameter int                 CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startOfFrame,
    input  logic [NUM_CH*RGB_W-1:0]     ch_rgb,
    input  logic [NUM_CH-1:0]           ch_draw_req,
    output logic [RGB_W-1:0]            out_rgb,
    output logic                        out_draw_req,
    output logic [$clog2(NUM_CH)-1:0]   out_ch_idx,
    output logic                        collision,
    output logic [NUM_CH-1:0]           live_coll_mask,
    output logic [NUM_CH-1:0]           frame_coll_mask,
    output logic [CNT_W-1:0]            frame_coll_cnt
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0] w_eff;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;
    logic              w_multi;
    logic              w_win;
    logic [RGB_W-1:0]  w_sel_rgb;

    logic [RGB_W-1:0]  r_rgb;
    logic              r_draw;
    logic [IDX_W-1:0]  r_idx;
    logic              r_coll;
    logic [NUM_CH-1:0] r_live_mask;
    logic [CNT_W-1:0]  r_live_cnt;
    logic [NUM_CH-1:0] r_frame_mask;
    logic [CNT_W-1:0]  r_frame_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A channel showing the key colour is treated as not requesting at all.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_eff[i] = ch_draw_req[i] &&
                       !(TRANSP_EN && (ch_rgb[i*RGB_W +: RGB_W] == TRANSP_RGB));
        end
    end

    priority_enc #(
        .NUM_CH (NUM_CH)
    ) u_enc (
        .i_eff   (w_eff),
        .o_idx   (w_idx),
        .o_any   (w_any),
        .o_multi (w_multi)
    );

    assign w_win = (MODE == MODE_ONEHOT) ? (w_any && !w_multi) : w_any;

    always_comb begin
        w_sel_rgb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_rgb = ch_rgb[i*RGB_W +: RGB_W];
            end
        end
    end

    // Pixel output stage: colour and index hold when nobody wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_draw <= 1'b0;
            r_rgb  <= '0;
            r_idx  <= '0;
            r_coll <= 1'b0;
        end else begin
            r_draw <= w_win;
            r_coll <= w_multi;
            if (w_win) begin
                r_rgb <= w_sel_rgb;
                r_idx <= w_idx;
            end
        end
    end

    // Frame accumulators: the startOfFrame pixel opens the new frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_live_mask  <= '0;
            r_live_cnt   <= '0;
            r_frame_mask <= '0;
            r_frame_cnt  <= '0;
        end else if (startOfFrame) begin
            r_frame_mask <= r_live_mask;
            r_frame_cnt  <= r_live_cnt;
            r_live_mask  <= w_multi ? w_eff : '0;
            r_live_cnt   <= w_multi ? CNT_W'(1) : '0;
        end else if (w_multi) begin
            r_live_mask  <= r_live_mask | w_eff;
            r_live_cnt   <= sat_inc(r_live_cnt);
        end
    end

    assign out_rgb         = r_rgb;
    assign out_draw_req    = r_draw;
    assign out_ch_idx      = r_idx;
    assign collision       = r_coll;
    assign live_coll_mask  = r_live_mask;
    assign frame_coll_mask = r_frame_mask;
    assign frame_coll_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_draw_priority_mux.sv
// Bench for draw_priority_mux: a priority-mode instance and a one-hot-mode
// instance with a 4-bit counter share stimulus and are checked against a model.
module tb_draw_priority_mux;

    logic         clk;
    logic         reset;
    logic         startOfFrame;
    logic [127:0] ch_rgb;
    logic [15:0]  ch_draw_req;

    logic [7:0]  d0_rgb, d1_rgb;
    logic        d0_draw, d1_draw;
    logic [3:0]  d0_idx, d1_idx;
    logic        d0_coll, d1_coll;
    logic [15:0] d0_lmask, d1_lmask;
    logic [15:0] d0_fmask, d1_fmask;
    logic [15:0] d0_fcnt;
    logic [3:0]  d1_fcnt;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    draw_priority_mux #(
        .NUM_CH(16), .RGB_W(8), .TRANSP_EN(1'b1), .TRANSP_RGB(8'hFF), .MODE(0), .CNT_W(16)
    ) dut0 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .ch_rgb(ch_rgb), .ch_draw_req(ch_draw_req),
        .out_rgb(d0_rgb), .out_draw_req(d0_draw), .out_ch_idx(d0_idx),
        .collision(d0_coll), .live_coll_mask(d0_lmask),
        .frame_coll_mask(d0_fmask), .frame_coll_cnt(d0_fcnt)
    );

    draw_priority_mux #(
        .NUM_CH(16), .RGB_W(8), .TRANSP_EN(1'b1), .TRANSP_RGB(8'hFF), .MODE(1), .CNT_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .ch_rgb(ch_rgb), .ch_draw_req(ch_draw_req),
        .out_rgb(d1_rgb), .out_draw_req(d1_draw), .out_ch_idx(d1_idx),
        .collision(d1_coll), .live_coll_mask(d1_lmask),
        .frame_coll_mask(d1_fmask), .frame_coll_cnt(d1_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        draw;
        logic [7:0]  rgb;
        logic [3:0]  idx;
        logic        coll;
        logic [15:0] lmask;
        logic [15:0] lcnt;
        logic [15:0] fmask;
        logic [15:0] fcnt;
    } mstate_t;

    mstate_t st0, st1;

    function automatic mstate_t next_state(input mstate_t s, input int mode, input int cntw,
                                           input logic [15:0] req, input logic [127:0] rgb,
                                           input logic sof);
        mstate_t n = s;
        logic [15:0] eff;
        int cnt;
        int first;
        int maxc;
        first = -1;
        for (int i = 0; i < 16; i++) eff[i] = req[i] && (rgb[i*8 +: 8] != 8'hFF);
        cnt = $countones(eff);
        for (int i = 15; i >= 0; i--) if (eff[i]) first = i;
        maxc = (1 << cntw) - 1;
        n.draw = (mode == 0) ? (cnt >= 1) : (cnt == 1);
        if (n.draw) begin
            n.rgb = rgb[first*8 +: 8];
            n.idx = 4'(first);
        end
        n.coll = (cnt >= 2);
        if (sof) begin
            n.fmask = s.lmask;
            n.fcnt  = s.lcnt;
            n.lmask = n.coll ? eff : 16'h0;
            n.lcnt  = n.coll ? 16'd1 : 16'd0;
        end else if (n.coll) begin
            n.lmask = s.lmask | eff;
            if (int'(s.lcnt) < maxc) n.lcnt = s.lcnt + 16'd1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            st0 <= '0;
            st1 <= '0;
        end else begin
            st0 <= next_state(st0, 0, 16, ch_draw_req, ch_rgb, startOfFrame);
            st1 <= next_state(st1, 1, 4,  ch_draw_req, ch_rgb, startOfFrame);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en && !reset) begin
            check("d0.draw",  32'(d0_draw),  32'(st0.draw));
            check("d0.rgb",   32'(d0_rgb),   32'(st0.rgb));
            check("d0.idx",   32'(d0_idx),   32'(st0.idx));
            check("d0.coll",  32'(d0_coll),  32'(st0.coll));
            check("d0.lmask", 32'(d0_lmask), 32'(st0.lmask));
            check("d0.fmask", 32'(d0_fmask), 32'(st0.fmask));
            check("d0.fcnt",  32'(d0_fcnt),  32'(st0.fcnt));
            check("d1.draw",  32'(d1_draw),  32'(st1.draw));
            check("d1.rgb",   32'(d1_rgb),   32'(st1.rgb));
            check("d1.idx",   32'(d1_idx),   32'(st1.idx));
            check("d1.coll",  32'(d1_coll),  32'(st1.coll));
            check("d1.lmask", 32'(d1_lmask), 32'(st1.lmask));
            check("d1.fmask", 32'(d1_fmask), 32'(st1.fmask));
            check("d1.fcnt",  32'(d1_fcnt),  32'(st1.fcnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rgb(input int ch, input logic [7:0] v);
        ch_rgb[ch*8 +: 8] = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".d0.draw"},  32'(d0_draw),  0);
        check({tag, ".d0.rgb"},   32'(d0_rgb),   0);
        check({tag, ".d0.idx"},   32'(d0_idx),   0);
        check({tag, ".d0.coll"},  32'(d0_coll),  0);
        check({tag, ".d0.lmask"}, 32'(d0_lmask), 0);
        check({tag, ".d0.fmask"}, 32'(d0_fmask), 0);
        check({tag, ".d0.fcnt"},  32'(d0_fcnt),  0);
        check({tag, ".d1.fcnt"},  32'(d1_fcnt),  0);
    endtask

    initial begin
        reset = 1'b0;
        startOfFrame = 1'b0;
        ch_rgb = '0;
        ch_draw_req = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        cmp_en = 1'b1;

        // Single request on channel 4
        ch_draw_req = 16'h0010; set_rgb(4, 8'h3C);
        step();
        check("single.draw", 32'(d0_draw), 1);
        check("single.rgb",  32'(d0_rgb),  32'h3C);
        check("single.idx",  32'(d0_idx),  4);
        check("single.coll", 32'(d0_coll), 0);
        check("single.d1draw", 32'(d1_draw), 1);

        // Priority and collision between channels 10 and 11
        ch_rgb = '0; ch_draw_req = 16'h0C00; set_rgb(10, 8'hE0); set_rgb(11, 8'h1F);
        step();
        check("prio.rgb",   32'(d0_rgb),   32'hE0);
        check("prio.idx",   32'(d0_idx),   10);
        check("prio.coll",  32'(d0_coll),  1);
        check("prio.lmask", 32'(d0_lmask), 32'h0C00);
        check("onehot.draw", 32'(d1_draw), 0);
        check("onehot.coll", 32'(d1_coll), 1);
        check("onehot.rgb",  32'(d1_rgb),  32'h3C);

        // Transparent channel 0 neither draws nor collides
        ch_rgb = '0; ch_draw_req = 16'h0003; set_rgb(0, 8'hFF); set_rgb(1, 8'h55);
        step();
        check("transp.idx",  32'(d0_idx),  1);
        check("transp.rgb",  32'(d0_rgb),  32'h55);
        check("transp.coll", 32'(d0_coll), 0);

        // Frame snapshot after 5 collisions between channels 2 and 7
        ch_rgb = '0; ch_draw_req = '0; startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        ch_draw_req = 16'h0084; set_rgb(2, 8'h11); set_rgb(7, 8'h22);
        repeat (5) step();
        ch_draw_req = '0; startOfFrame = 1'b1;
        step();
        check("snap.fcnt",  32'(d0_fcnt),  5);
        check("snap.fmask", 32'(d0_fmask), 32'h0084);
        check("snap.lmask", 32'(d0_lmask), 0);
        check("model.fcnt", 32'(st0.fcnt), 5);
        startOfFrame = 1'b0;

        // Collision on the startOfFrame pixel belongs to the new frame
        ch_draw_req = 16'h0084;
        repeat (2) step();
        startOfFrame = 1'b1;
        step();
        check("sofcoll.fcnt",  32'(d0_fcnt),  2);
        check("sofcoll.lmask", 32'(d0_lmask), 32'h0084);
        ch_draw_req = '0;
        step();
        check("sofcoll.next.fcnt",  32'(d0_fcnt),  1);
        check("sofcoll.next.fmask", 32'(d0_fmask), 32'h0084);
        startOfFrame = 1'b0;

        // Saturation: 20 collisions
        ch_draw_req = 16'h0084;
        repeat (20) step();
        ch_draw_req = '0; startOfFrame = 1'b1;
        step();
        check("sat.d0.fcnt", 32'(d0_fcnt), 20);
        check("sat.d1.fcnt", 32'(d1_fcnt), 15);
        step();
        check("empty.fcnt",  32'(d0_fcnt),  0);
        check("empty.fmask", 32'(d0_fmask), 0);
        startOfFrame = 1'b0;

        // Hold on idle
        ch_rgb = '0; ch_draw_req = 16'h0008; set_rgb(3, 8'hA5);
        step();
        ch_draw_req = '0;
        repeat (3) step();
        check("hold.draw", 32'(d0_draw), 0);
        check("hold.rgb",  32'(d0_rgb),  32'hA5);
        check("hold.idx",  32'(d0_idx),  3);
        check("hold.d1rgb", 32'(d1_rgb), 32'hA5);

        // Asynchronous reset mid-frame
        ch_rgb = '0; ch_draw_req = 16'h0084;
        repeat (3) step();
        reset = 1'b1;
        #2;
        check_all_zero("midreset");
        step();
        reset = 1'b0;
        repeat (2) step();
        ch_draw_req = '0; startOfFrame = 1'b1;
        step();
        check("postreset.fcnt",  32'(d0_fcnt),  2);
        check("postreset.fmask", 32'(d0_fmask), 32'h0084);
        startOfFrame = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 3))
                0: ch_draw_req = '0;
                1: ch_draw_req = 16'h1 << $urandom_range(0, 15);
                2: ch_draw_req = 16'($urandom & $urandom & $urandom);
                default: ch_draw_req = 16'($urandom);
            endcase
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 3) == 0) set_rgb(i, 8'hFF);
                else set_rgb(i, 8'($urandom));
            end
            startOfFrame = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_priority_mux.md
Name: draw_priority_mux

Overview:
- Parametrised N-channel draw-request multiplexer for the VGA object layer.
- Each cycle it selects one drawing object from the requesting channels and outputs that object's pixel colour, registered.
- Adds several features:
  - transparent-colour keying;
  - selectable arbitration mode (priority or strict one-hot);
  - per-frame collision detection, with sticky channel masks and a saturating collision-pixel counter for game logic.
- Sits between the per-object drawers (bonuses, bricks, ball) and the top-level VGA colour mux.

Parameters:
- NUM_CH, 16, number of object channels (2..32).
- RGB_W, 8, colour width per channel.
- TRANSP_EN, 1, 1 = a channel whose colour equals TRANSP_RGB is treated as not requesting.
- TRANSP_RGB, 8'hFF, transparent colour key (RGB_W bits).
- MODE, 0, 0 = priority (lowest index wins); 1 = strict one-hot (draw only if exactly one effective request).
- CNT_W, 16, width of the collision-pixel counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame.
- ch_rgb  in  NUM_CH x RGB_W  packed per-channel colours.
- ch_draw_req  in  NUM_CH  per-channel draw requests.
- out_rgb  out  RGB_W  selected colour, registered.
- out_draw_req  out  1  a channel won this pixel, registered.
- out_ch_idx  out  $clog2(NUM_CH)  index of the winning channel, registered.
- collision  out  1  registered pulse: two or more effective requests on this pixel.
- live_coll_mask  out  NUM_CH  sticky OR of the channels involved in collisions during the current frame.
- frame_coll_mask  out  NUM_CH  snapshot of live_coll_mask taken at startOfFrame (previous frame).
- frame_coll_cnt  out  CNT_W  snapshot of the collision-pixel count of the previous frame.

Behaviour:
- Reset: every output and every internal register is 0, including out_rgb, out_ch_idx and both live accumulators.
- Effective request:
  - eff[i] = ch_draw_req[i] && !(TRANSP_EN && ch_rgb[i]==TRANSP_RGB).
  - Combinational, sampled in the same cycle.
- Winner selection, MODE 0:
  - the lowest i with eff[i]=1 wins;
  - out_draw_req<=1, out_rgb<=ch_rgb[i], out_ch_idx<=i.
- Winner selection, MODE 1:
  - draws only when popcount(eff)==1, using the same assignments as MODE 0;
  - with two or more requests, out_draw_req<=0.
- No winner: out_draw_req<=0; out_rgb and out_ch_idx hold their previous values.
- Latency: exactly 1 clock from inputs to out_*/collision. There is no back-pressure and no stall.
- Collision:
  - coll_now = popcount(eff)>=2;
  - collision<=coll_now;
  - live_coll_mask |= eff when coll_now;
  - the live counter increments by 1 when coll_now and saturates at 2^CNT_W-1 (no wrap).
- Frame boundary (startOfFrame=1):
  - frame_coll_mask<=live_coll_mask and frame_coll_cnt<=live counter, both pre-update values;
  - the live mask and live counter restart from this pixel: the mask loads (coll_now ? eff : 0) and the counter loads (coll_now ? 1 : 0).
  - A collision on the startOfFrame pixel therefore belongs to the new frame.
- Back-to-back startOfFrame pulses: each pulse snapshots and restarts. Snapshots of an empty frame are 0.
- Reset mid-frame: all accumulators and snapshots clear immediately. The first snapshot after reset reflects only the post-reset pixels.
- A NUM_CH channel with all-zero requests produces no draw and no collision.

Decomposition:
- Package draw_mux_pkg:
  - constants DEFAULT_TRANSP_RGB (8'hFF);
  - MODE encodings MODE_PRIORITY=0 and MODE_ONEHOT=1;
  - function clog2-safe index width.
- Sub-module priority_enc, NUM_CH-parametrised and combinational:
  - inputs eff;
  - outputs idx, any, multi (popcount>=2).
- The top-level module holds all registers and the frame accumulators.

Test Plan:
- Reset and single request:
  - assert reset mid-stream → all outputs 0 asynchronously;
  - release reset, MODE 0, ch_draw_req=16'h0010, ch_rgb[4]=8'h3C → next cycle out_draw_req=1, out_rgb=8'h3C, out_ch_idx=4, collision=0.
- Priority and collision:
  - MODE 0, req=16'h0C00, rgb[10]=8'hE0, rgb[11]=8'h1F → out_rgb=8'hE0, idx=10, collision=1, live_coll_mask=16'h0C00.
  - In MODE 1, the same stimulus gives out_draw_req=0, collision=1, and out_rgb holding its prior value.
- Transparency:
  - req=16'h0003, rgb[0]=8'hFF, rgb[1]=8'h55 → idx=1, out_rgb=8'h55, collision=0 (the transparent channel does not collide).
- Frame snapshot:
  - 5 collision pixels between channels 2 and 7, then startOfFrame with no requests → frame_coll_cnt=5, frame_coll_mask=16'h0084, live accumulators=0.
  - A collision on the startOfFrame pixel → live counter=1 and frame_coll_cnt excludes that pixel.
- Saturation with CNT_W=4:
  - 20 consecutive collision pixels, then startOfFrame → frame_coll_cnt=15.
- Hold on idle:
  - draw 8'hA5 on channel 3, then req=0 for 3 cycles → out_draw_req=0, out_rgb stays 8'hA5, out_ch_idx stays 3.
